// File: rtl/i2c_slave_regfile_if.sv
// Bus-side and host-side signal bundle for the I2C target register file.
// The slave modport is what the block itself sees; master is the
// environment (pins plus local host port).
interface i2c_slave_regfile_if #(
  parameter int PW = 4
);
  logic          scl_i;
  logic          sda_i;
  logic          sda_oe;
  logic          reg_wr;
  logic [PW-1:0] reg_waddr;
  logic [7:0]    reg_wdata;
  logic [PW-1:0] host_raddr;
  logic [7:0]    host_rdata;
  logic          busy;

  modport slave (
    input  scl_i, sda_i, host_raddr,
    output sda_oe, reg_wr, reg_waddr, reg_wdata, host_rdata, busy
  );

  modport master (
    output scl_i, sda_i, host_raddr,
    input  sda_oe, reg_wr, reg_waddr, reg_wdata, host_rdata, busy
  );
endinterface

// File: rtl/i2c_slave_regfile.sv
// I2C target with an 8-bit register file. First written byte after the
// address sets the register pointer, later bytes are stored; reads return
// regs[ptr]. The pointer auto-increments, wraps and survives transactions.
//
// state    | meaning
// IDLE     | bus free, waiting for START
// ADDR     | shifting in address byte
// ADDR_ACK | driving ACK for the address (assert on 1st fall, release on 2nd)
// RX_BYTE  | shifting in a write data byte
// RX_ACK   | driving ACK for a received data byte
// TX_BYTE  | driving a read byte, one bit per SCL fall
// TX_ACK   | sampling master ACK/NACK
// IGNORE   | not addressed or NACKed, wait for START/STOP
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         NUM_REGS   = 16
) (
  input logic                clk,
  input logic                rst_n,
  i2c_slave_regfile_if.slave bus
);
  localparam int PW = $clog2(NUM_REGS);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, IGNORE
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    scl_sync_q, sda_sync_q;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          first_q, first_d;
  logic          rw_q, rw_d;
  logic          ack_seen_q, ack_seen_d;
  logic          sda_oe_q, sda_oe_d;
  logic          reg_wr_q, reg_wr_d;
  logic [PW-1:0] reg_waddr_q, reg_waddr_d;
  logic [7:0]    reg_wdata_q, reg_wdata_d;
  logic [7:0]    regs_q [NUM_REGS];

  logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  // bits [1] are the synchronized pin values, bits [2] the edge-detect copy
  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall  = ~scl_sync_q[1] & scl_sync_q[2];
  assign start_det = scl_s & sda_sync_q[2] & ~sda_sync_q[1];
  assign stop_det  = scl_s & ~sda_sync_q[2] & sda_sync_q[1];
  assign rx_byte   = {shift_q[6:0], sda_s};

  assign bus.sda_oe     = sda_oe_q;
  assign bus.reg_wr     = reg_wr_q;
  assign bus.reg_waddr  = reg_waddr_q;
  assign bus.reg_wdata  = reg_wdata_q;
  assign bus.host_rdata = regs_q[bus.host_raddr];
  assign bus.busy       = (state_q == ADDR_ACK) || (state_q == RX_BYTE) ||
                          (state_q == RX_ACK)   || (state_q == TX_BYTE) ||
                          (state_q == TX_ACK);

  // pin synchronizers, reset to the idle-high bus level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
    end else begin
      scl_sync_q <= {scl_sync_q[1:0], bus.scl_i};
      sda_sync_q <= {sda_sync_q[1:0], bus.sda_i};
    end
  end

  // FSM and datapath state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      first_q     <= 1'b0;
      rw_q        <= 1'b0;
      ack_seen_q  <= 1'b0;
      sda_oe_q    <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      first_q     <= first_d;
      rw_q        <= rw_d;
      ack_seen_q  <= ack_seen_d;
      sda_oe_q    <= sda_oe_d;
      reg_wr_q    <= reg_wr_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

  // register file; the write lands at the same edge that raises reg_wr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (reg_wr_d) begin
      regs_q[reg_waddr_d] <= reg_wdata_d;
    end
  end

  // next-state logic; STOP/START override any bit-level activity
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    first_d     = first_q;
    rw_d        = rw_q;
    ack_seen_d  = ack_seen_q;
    sda_oe_d    = sda_oe_q;
    reg_wr_d    = 1'b0;
    reg_waddr_d = reg_waddr_q;
    reg_wdata_d = reg_wdata_q;

    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
    end else if (start_det) begin
      state_d    = ADDR;
      bit_cnt_d  = 3'd7;
      first_d    = 1'b1;
      ack_seen_d = 1'b0;
      sda_oe_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            if (bit_cnt_q == 3'd0) begin
              if (shift_q[6:0] == SLAVE_ADDR) begin
                state_d = ADDR_ACK;
                rw_d    = sda_s;
              end else begin
                state_d = IGNORE;
              end
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end
        end
        // sda_oe doubles as the ACK phase flag: low = not yet asserted
        ADDR_ACK, RX_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (state_q == ADDR_ACK && rw_q) begin
              state_d   = TX_BYTE;
              shift_d   = regs_q[ptr_q];
              ptr_d     = ptr_q + PTR_ONE;
              sda_oe_d  = ~regs_q[ptr_q][7];
              bit_cnt_d = 3'd7;
            end else begin
              state_d   = RX_BYTE;
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd7;
            end
          end
        end
        RX_BYTE: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            if (bit_cnt_q == 3'd0) begin
              state_d = RX_ACK;
              if (first_q) begin
                ptr_d   = rx_byte[PW-1:0];
                first_d = 1'b0;
              end else begin
                reg_wr_d    = 1'b1;
                reg_waddr_d = ptr_q;
                reg_wdata_d = rx_byte;
                ptr_d       = ptr_q + PTR_ONE;
              end
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end
        end
        // bit_cnt holds the index currently on the bus
        TX_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd0) begin
              state_d    = TX_ACK;
              sda_oe_d   = 1'b0;
              ack_seen_d = 1'b0;
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
              sda_oe_d  = ~shift_q[bit_cnt_q - 3'd1];
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              ack_seen_d = 1'b1;
              shift_d    = regs_q[ptr_q];
              ptr_d      = ptr_q + PTR_ONE;
            end else begin
              state_d = IGNORE;
            end
          end else if (scl_fall && ack_seen_q) begin
            state_d    = TX_BYTE;
            bit_cnt_d  = 3'd7;
            sda_oe_d   = ~shift_q[7];
            ack_seen_d = 1'b0;
          end
        end
        IGNORE: sda_oe_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end
endmodule
